fetch_unit: RTL and testbench

Instruction fetch stage that owns the architectural fetch PC and feeds the decode stage. It issues one instruction-memory request at a time, buffers returned instructions with their PCs in a 2-entry queue, and accepts PC redirects from the branch unit. On a redirect it flushes queued instructions and discards any response already in flight. It sits between instruction memory and decode, and closes the loop with the branch unit's next-PC / taken outputs.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_insn_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types and constants: instruction address/word widths,
// sequential increment, reset PC and the queue entry layout.
package fetch_unit_pkg;

    localparam int unsigned INSN_ADDR_WIDTH = 30;
    localparam int unsigned INSN_WIDTH      = 32;

    typedef logic [INSN_ADDR_WIDTH-1:0] insn_addr_t;
    typedef logic [INSN_WIDTH-1:0]      insn_word_t;

    localparam insn_addr_t INSN_PC_INC = insn_addr_t'(1);
    localparam insn_addr_t RESET_PC    = '0;

    typedef struct packed {
        insn_word_t insn;
        insn_addr_t pc;
    } queue_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: branch redirect in, instruction-memory request/response,
// and the decode-side valid/ready instruction stream.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic       brRedirect;
    insn_addr_t brTarget;
    logic       imemReq;
    insn_addr_t imemAddr;
    logic       imemAck;
    insn_word_t imemData;
    logic       insnValid;
    insn_word_t insn;
    insn_addr_t insnPC;
    logic       insnReady;

    modport master (
        input  brRedirect, brTarget, imemAck, imemData, insnReady,
        output imemReq, imemAddr, insnValid, insn, insnPC
    );

    modport slave (
        output brRedirect, brTarget, imemAck, imemData, insnReady,
        input  imemReq, imemAddr, insnValid, insn, insnPC
    );

endinterface

// File: rtl/fetch_unit_insn_queue.sv
// Two-entry FIFO holding fetched {insn, pc} pairs; flush wins over push/pop.
module insn_queue #(
    parameter int unsigned WIDTH = 62
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             pop_eff;

    assign pop_eff = pop && (count != 2'd0);
    assign head    = slot0;

    // slot0 is always the head; entries shift down on pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            unique case ({push, pop_eff})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_eff && !flush && count == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight,
// queues responses for decode and restarts on branch redirects.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t       state, state_n;
    insn_addr_t   next_pc, next_pc_n;
    insn_addr_t   req_addr, req_addr_n;
    logic         push, pop, flush;
    logic [1:0]   count, cnt_after;
    queue_entry_t head;

    insn_queue #(.WIDTH($bits(queue_entry_t))) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({bus.imemData, req_addr}),
        .head  (head),
        .count (count)
    );

    assign bus.imemReq   = (state != IDLE);
    assign bus.imemAddr  = req_addr;
    assign bus.insnValid = (count != 2'd0);
    assign bus.insn      = head.insn;
    assign bus.insnPC    = head.pc;

    assign pop       = bus.insnValid && bus.insnReady;
    assign cnt_after = count - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            next_pc  <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            next_pc  <= next_pc_n;
            req_addr <= req_addr_n;
        end
    end

    // A slot is reserved before issuing, so an acked response always fits
    always_comb begin
        state_n    = state;
        next_pc_n  = next_pc;
        req_addr_n = req_addr;
        push       = 1'b0;
        flush      = bus.brRedirect;
        if (bus.brRedirect) next_pc_n = bus.brTarget;

        unique case (state)
            IDLE: begin
                if (!bus.brRedirect && cnt_after < 2'd2) begin
                    req_addr_n = next_pc;
                    next_pc_n  = next_pc + INSN_PC_INC;
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (bus.imemAck) begin
                    state_n = IDLE;
                    if (!bus.brRedirect) begin
                        push = 1'b1;
                        if (cnt_after == 2'd0) begin
                            req_addr_n = next_pc;
                            next_pc_n  = next_pc + INSN_PC_INC;
                            state_n    = REQ;
                        end
                    end
                end else if (bus.brRedirect) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                if (bus.imemAck) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked against
// a stream-level model (expected fetch address sequence and delivered-instruction queue).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic [29:0] pc;
        logic [31:0] insn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops    = 0;

    exp_t        q[$];
    logic [29:0] exp_addr;
    logic [29:0] open_addr;
    logic        open_req;
    logic        discard;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_addr  = 30'd0;
        open_addr = 30'd0;
        open_req  = 1'b0;
        discard   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        bus.imemAck    = 1'b0;
        bus.insnReady  = 1'b0;
        bus.brRedirect = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_imemReq", 64'(bus.imemReq), 64'd0);
        chk("rst_insnValid", 64'(bus.insnValid), 64'd0);
        chk("rst_imemAddr", 64'(bus.imemAddr), 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: drive inputs at negedge, check outputs against the model,
    // advance the model by what this cycle means, then cross the clock edge.
    task automatic step(input logic a, input logic r, input logic d, input logic [29:0] t);
        logic [29:0] cur;
        logic        popped;
        cur            = open_addr;
        bus.imemAck    = a & bus.imemReq;
        bus.imemData   = mem_fn(bus.imemAddr);
        bus.insnReady  = r;
        bus.brRedirect = d;
        bus.brTarget   = t;
        #1;
        chk("insnValid", 64'(bus.insnValid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("insnPC", 64'(bus.insnPC), 64'(q[0].pc));
            chk("insn", 64'(bus.insn), 64'(q[0].insn));
        end
        if (bus.imemReq) begin
            if (!open_req) begin
                chk("req_addr", 64'(bus.imemAddr), 64'(exp_addr));
                cur      = exp_addr;
                exp_addr = exp_addr + 30'd1;
            end else begin
                chk("req_hold", 64'(bus.imemAddr), 64'(open_addr));
            end
        end
        popped = (q.size() != 0) && r;
        if (d) begin
            q.delete();
        end else begin
            if (popped) begin
                void'(q.pop_front());
                pops++;
            end
            if (bus.imemAck && !discard) q.push_back('{cur, mem_fn(cur)});
        end
        if (bus.imemAck) discard = 1'b0;
        else if (bus.imemReq && d) discard = 1'b1;
        open_req  = bus.imemReq && !bus.imemAck;
        open_addr = cur;
        if (d) exp_addr = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.imemAck    = 1'b0;
        bus.imemData   = '0;
        bus.insnReady  = 1'b0;
        bus.brRedirect = 1'b0;
        bus.brTarget   = '0;
        model_reset();

        // Free run: first request two cycles after reset, then 1 insn/cycle
        do_reset(2);
        chk("c1_imemReq", 64'(bus.imemReq), 64'd0);
        step(1, 1, 0, 0);
        chk("c2_imemReq", 64'(bus.imemReq), 64'd1);
        chk("c2_imemAddr", 64'(bus.imemAddr), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            chk("run_valid", 64'(bus.insnValid), 64'd1);
            chk("run_pc", 64'(bus.insnPC), 64'(i));
        end

        // Decode stalled: exactly two requests, then fetch stops with queue full
        do_reset(2);
        step(1, 0, 0, 0);
        chk("stall_a0", 64'(bus.imemAddr), 64'd0);
        step(1, 0, 0, 0);
        chk("stall_a1", 64'(bus.imemAddr), 64'd1);
        step(1, 0, 0, 0);
        chk("stall_noreq", 64'(bus.imemReq), 64'd0);
        step(1, 0, 0, 0);
        chk("stall_noreq2", 64'(bus.imemReq), 64'd0);
        chk("stall_head", 64'(bus.insnPC), 64'd0);
        step(1, 1, 0, 0);
        chk("resume_head", 64'(bus.insnPC), 64'd1);
        chk("resume_addr", 64'(bus.imemAddr), 64'd2);
        chk("resume_req", 64'(bus.imemReq), 64'd1);

        // Redirect with an ack in the same cycle: queue flushed, response dropped
        step(1, 0, 1, 30'h100);
        chk("redir_valid", 64'(bus.insnValid), 64'd0);
        chk("redir_idle", 64'(bus.imemReq), 64'd0);
        step(0, 0, 0, 0);
        chk("redir_addr", 64'(bus.imemAddr), 64'h100);
        chk("redir_req", 64'(bus.imemReq), 64'd1);

        // Redirect with ack pending: address held until the late ack
        step(0, 0, 1, 30'h40);
        chk("drop_hold0", 64'(bus.imemAddr), 64'h100);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("drop_hold2", 64'(bus.imemAddr), 64'h100);
        step(1, 0, 0, 0);
        chk("drop_idle", 64'(bus.imemReq), 64'd0);
        chk("drop_empty", 64'(bus.insnValid), 64'd0);
        step(0, 0, 0, 0);
        chk("drop_new", 64'(bus.imemAddr), 64'h40);

        // Two redirects while dropping: the later target wins
        step(0, 0, 1, 30'h40);
        step(0, 0, 1, 30'h80);
        step(1, 0, 0, 0);
        chk("dd_idle", 64'(bus.imemReq), 64'd0);
        step(0, 0, 0, 0);
        chk("dd_addr", 64'(bus.imemAddr), 64'h80);

        // Sequential PC wraps at the top of the address space
        step(1, 1, 1, 30'h3FFF_FFFF);
        step(0, 1, 0, 0);
        chk("wrap_top", 64'(bus.imemAddr), 64'h3FFF_FFFF);
        step(1, 1, 0, 0);
        chk("wrap_zero", 64'(bus.imemAddr), 64'd0);
        chk("wrap_pc", 64'(bus.insnPC), 64'h3FFF_FFFF);

        // Reset pulse while a request is outstanding
        chk("pre_rst_req", 64'(bus.imemReq), 64'd1);
        do_reset(1);

        for (int i = 0; i < 2000; i++) begin
            logic        a, r, d;
            logic [29:0] t;
            a = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FFFC | 30'($urandom_range(0, 3)))
                                            : 30'($urandom);
            step(a, r, d, t);
        end
        chk("liveness", 64'(pops >= 200), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
